// File: rtl/add_share_arbiter_pkg.sv
// Shared constants and helpers for the adder-sharing arbiters in the pipeline.
package add_share_arbiter_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_NREQ = 8;

  // Tag width for n requesters; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_share_arbiter_adder.sv
// Combinational 32-bit adder shared by pipeline requesters; carry out is dropped.
module add_share_arbiter_adder
  import add_share_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/add_share_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ requesters, with a single
// registered response slot tagged by requester ID.
module add_share_arbiter
  import add_share_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned ID_W = clog2_min1(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DATA_W-1:0]      rsp_sum,
  input  logic                   rsp_ready
);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_sum_q, rsp_sum_d;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W:0]     scan_idx;
  logic [ID_W:0]     gnt_inc;
  logic              slot_free;
  logic              accept;
  logic [DATA_W-1:0] op_a, op_b, sum;

  // Scan from ptr upward with an explicit wrap, so non-power-of-two NREQ works.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NREQ)) begin
        scan_idx = scan_idx - (ID_W+1)'(NREQ);
      end
      if (!gnt_found && req_valid[scan_idx[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    op_a = req_a[DATA_W*int'(gnt_idx) +: DATA_W];
    op_b = req_b[DATA_W*int'(gnt_idx) +: DATA_W];
  end

  add_share_arbiter_adder u_adder (
    .a_i   (op_a),
    .b_i   (op_b),
    .sum_o (sum)
  );

  always_comb begin
    slot_free = !rsp_valid_q || rsp_ready;
    accept    = gnt_found && slot_free && !rst;
    req_ready = '0;
    if (accept) begin
      req_ready[gnt_idx] = 1'b1;
    end

    gnt_inc = {1'b0, gnt_idx} + (ID_W+1)'(1);
    ptr_d   = ptr_q;
    if (accept) begin
      ptr_d = (gnt_inc == (ID_W+1)'(NREQ)) ? '0 : gnt_inc[ID_W-1:0];
    end

    // Drain and accept in the same cycle keep the slot full.
    rsp_valid_d = accept || (rsp_valid_q && !rsp_ready);
    rsp_id_d    = accept ? gnt_idx : rsp_id_q;
    rsp_sum_d   = accept ? sum : rsp_sum_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Scoreboard bench for add_share_arbiter with three requesters.
module tb_add_share_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned ID_W = 2;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_a;
  logic [NREQ*32-1:0]  req_b;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [31:0]         rsp_sum;
  logic                rsp_ready;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     sum;
  } rsp_t;

  rsp_t        sb_q[$];
  int unsigned m_ptr;
  int          wait_cnt[NREQ];
  logic        m_acc;
  int unsigned m_acc_idx;
  int          n_checks;
  int          n_fail;

  add_share_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_ready (rsp_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int unsigned i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // Reference model, evaluated mid-cycle; updates model state for the coming edge.
  task automatic model_eval();
    logic [NREQ-1:0]   exp_ready;
    logic              found;
    int unsigned       gi;
    int unsigned       idx;
    logic [NREQ*32-1:0] a_v;
    logic [NREQ*32-1:0] b_v;
    rsp_t              e;
    exp_ready = '0;
    found     = 1'b0;
    gi        = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gi    = idx;
      end
    end
    if (found && (sb_q.size() == 0 || rsp_ready)) exp_ready[gi] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(sb_q.size() != 0));
    if (sb_q.size() != 0) begin
      check_eq("rsp_id", 32'(rsp_id), 32'(sb_q[0].id));
      check_eq("rsp_sum", rsp_sum, sb_q[0].sum);
      if (rsp_ready) void'(sb_q.pop_front());
    end
    m_acc     = (exp_ready != '0);
    m_acc_idx = gi;
    if (m_acc) begin
      a_v   = req_a;
      b_v   = req_b;
      e.id  = ID_W'(gi);
      e.sum = a_v[32*gi +: 32] + b_v[32*gi +: 32];
      sb_q.push_back(e);
      check_eq("fair_wait", 32'(wait_cnt[gi] > int'(NREQ) - 1), 32'(0));
      m_ptr = (gi + 1) % NREQ;
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!req_valid[j] || (m_acc && j == gi)) wait_cnt[j] = 0;
      else if (m_acc) wait_cnt[j]++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    sb_q.delete();
    m_ptr = 0;
    foreach (wait_cnt[j]) wait_cnt[j] = 0;
    @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m_ptr     = 0;
    m_acc     = 1'b0;
    m_acc_idx = 0;
    foreach (wait_cnt[j]) wait_cnt[j] = 0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    rst       = 1'b1;
    #1;
    check_eq("reset_valid", 32'(rsp_valid), 32'(0));
    check_eq("reset_id", 32'(rsp_id), 32'(0));
    check_eq("reset_sum", rsp_sum, 32'(0));
    apply_reset();
    req_valid = '0;

    // Single requester
    req_valid = 3'b001;
    set_ops(0, 32'd5, 32'd7);
    rsp_ready = 1'b1;
    step();
    req_valid = '0;
    check_eq("single_valid", 32'(rsp_valid), 32'(1));
    check_eq("single_id", 32'(rsp_id), 32'(0));
    check_eq("single_sum", rsp_sum, 32'd12);
    step();

    // Contention and wrap
    apply_reset();
    for (int unsigned i = 0; i < NREQ; i++) set_ops(i, 32'h100 * i, 32'(i + 1));
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("rr_order", 32'(req_ready), 32'(1 << (k % 3)));
      model_eval();
      @(posedge clk);
      #1;
      check_eq("rr_rsp_id", 32'(rsp_id), 32'(k % 3));
    end
    @(negedge clk);
    check_eq("ptr_wrap", 32'(req_ready), 32'(1));
    model_eval();
    @(posedge clk);
    #1;
    req_valid = '0;
    step();

    // Backpressure then simultaneous drain and accept
    apply_reset();
    req_valid = 3'b001;
    set_ops(0, 32'h8, 32'h8);
    rsp_ready = 1'b1;
    step();
    req_valid = 3'b011;
    set_ops(0, 32'd1, 32'd2);
    set_ops(1, 32'd3, 32'd4);
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("bp_ready", 32'(req_ready), 32'(0));
      check_eq("bp_sum", rsp_sum, 32'h10);
      model_eval();
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_resume", 32'(req_ready), 32'(3'b010));
    model_eval();
    @(posedge clk);
    #1;
    check_eq("bp_valid", 32'(rsp_valid), 32'(1));
    check_eq("bp_new_sum", rsp_sum, 32'd7);
    check_eq("bp_new_id", 32'(rsp_id), 32'(1));
    req_valid = 3'b001;
    step();
    req_valid = '0;
    step();

    // Overflow wrap
    req_valid = 3'b100;
    set_ops(2, 32'hFFFF_FFFF, 32'h1);
    step();
    check_eq("ovf_sum", rsp_sum, 32'h0);
    check_eq("ovf_id", 32'(rsp_id), 32'(2));
    set_ops(2, 32'h7FFF_FFFF, 32'h1);
    step();
    check_eq("sovf_sum", rsp_sum, 32'h8000_0000);
    req_valid = '0;
    step();

    // Asynchronous reset mid-operation
    req_valid = 3'b010;
    set_ops(1, 32'd9, 32'd9);
    rsp_ready = 1'b0;
    step();
    req_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_valid", 32'(rsp_valid), 32'(0));
    check_eq("async_id", 32'(rsp_id), 32'(0));
    check_eq("async_sum", rsp_sum, 32'(0));
    apply_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("rst_prio", 32'(req_ready), 32'(1));
    model_eval();
    @(posedge clk);
    #1;
    req_valid = '0;
    step();

    // Random soak
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          set_ops(i, $urandom, $urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
      if (m_acc) req_valid[m_acc_idx] = 1'b0;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();
    check_eq("sb_empty", 32'(sb_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_share_arbiter.md
# add_share_arbiter

Round-robin arbiter that shares a single 32-bit adder between up to NREQ requesters in the MIPS pipeline, for example the PC+4 incrementer and the branch-target calculator. Each requester uses a valid/ready handshake. Granted operand pairs pass through the adder into one registered response slot, and the slot is tagged with the requester ID. The block replaces per-stage adders where area matters more than a zero-latency sum.

## Interface
Parameters:
- NREQ, 2: number of requesters, 2..8.
- ID_W, $clog2(NREQ) (minimum 1): width of the response tag.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- req_valid, input, NREQ: bit i means requester i presents operands.
- req_a, input, NREQ*32: flattened operand A; requester i uses bits [32*i+31 : 32*i].
- req_b, input, NREQ*32: flattened operand B, same packing as req_a.
- req_ready, output, NREQ: bit i means requester i is accepted this cycle; at most one bit is high.
- rsp_valid, output, 1: the response slot holds a sum.
- rsp_id, output, ID_W: index of the requester that owns rsp_sum.
- rsp_sum, output, 32: the sum, req_a + req_b modulo 2^32.
- rsp_ready, input, 1: the consumer takes the response this cycle.

## Operation
- The grant is combinational and round-robin.
  - Search starts at requester ptr and wraps modulo NREQ.
  - The first i with req_valid[i]=1 is granted.
- Slot free condition: slot_free = !rsp_valid || rsp_ready.
- req_ready[i] = grant[i] && slot_free. It is 0 for every requester when no requester is valid.
- Accept is defined as req_valid[i] && req_ready[i]. On an accept:
  - the slot loads req_a[i]+req_b[i] and i;
  - rsp_valid is set to 1;
  - ptr becomes (i+1) mod NREQ.
- ptr does not move without an accept, so a stalled grant does not lose fairness.
- Drain: when rsp_valid && rsp_ready with no accept in the same cycle, rsp_valid clears. rsp_sum and rsp_id hold their last values.
- Simultaneous drain and accept: the slot reloads with the new result and rsp_valid stays 1, giving a throughput of 1 per cycle.
- Backpressure: while rsp_valid && !rsp_ready, all req_ready bits are 0 and rsp_valid, rsp_id and rsp_sum hold stable.
- Requester obligation: once req_valid is asserted, the requester holds req_valid, req_a and req_b stable until it is accepted. The grant may move to another requester while no accept occurs.
- Arithmetic: unsigned 32-bit sum, no carry out and no overflow flag. Example: 0xFFFFFFFF+1 = 0x00000000. Signed overflow is ignored.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_sum=0, ptr=0.
  - req_ready is 0 during reset.
  - Reset in the middle of an operation discards any pending response.
- Requester indices ≥ NREQ do not exist. The ptr wrap uses an explicit compare, not a power-of-two mask.

## Timing
- Latency: an accept in cycle t gives rsp_valid=1 with its data at the rising edge ending t, i.e. visible in cycle t+1.
- Throughput: one sum per cycle while rsp_ready is held high.
- Combinational paths:
  - req_valid → req_ready;
  - rsp_ready → req_ready;
  - the operand mux → adder → slot D input.
- No combinational path from req_* to rsp_*.
- Fairness: with all requesters continuously valid and rsp_ready=1, each requester is accepted exactly once every NREQ cycles.

## Structure
- Shared include header holds:
  - DATA_W = 32;
  - the maximum NREQ (8);
  - a clog2 helper macro, used by other arbiters in the pipeline.
- The only natural sub-module is the team's existing combinational 32-bit adder. Instantiate it once, fed by the granted-operand mux.
- The grant logic (rotate, priority-encode, rotate back) stays inline.

## Test plan
- Single requester: after reset, req_valid=01, a0=5, b0=7, rsp_ready=1 → req_ready=01 in that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_sum=12.
- Contention and wrap, NREQ=3: all valid, rsp_ready=1 for 6 cycles → accept order 0,1,2,0,1,2; rsp_id follows one cycle later; ptr returns to 0.
- Backpressure: slot full with sum 0x10 and rsp_ready=0 for 4 cycles while req_valid=11 →
  - req_ready=00 throughout;
  - rsp_sum stays 0x10;
  - when rsp_ready rises, accept and drain happen in the same cycle;
  - rsp_valid stays 1 with the new sum.
- Overflow: a=0xFFFFFFFF, b=0x00000001 → rsp_sum=0x00000000. a=0x7FFFFFFF, b=1 → rsp_sum=0x80000000.
- Reset mid-operation: assert rst asynchronously while rsp_valid=1 → rsp_valid, rsp_id and rsp_sum go to 0 immediately, without a clock. After release, requester 0 has first priority.
- Fairness soak: random req_valid and rsp_ready for 10k cycles; a scoreboard checks:
  - every accepted pair's sum, ID and order;
  - no requester waits more than NREQ accepts while continuously valid.
